// File: rtl/alu_selftest.sv
// Built-in sweep tester for a 4-bit, 8-op ALU: applies all 2048 vectors and records mismatches.
// Optional macro ALU_SELFTEST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module alu_selftest #(
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [3:0] alu_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [11:0] err_count,
   output logic [3:0] fail_a,
   output logic [3:0] fail_b,
   output logic [2:0] fail_op,
   output logic [3:0] fail_out
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [10:0] IDX_LAST    = 11'd2047;
   localparam logic [11:0] ERR_MAX     = 12'd2048;

   state_t      state_r;
   logic [10:0] idx_r;
   logic [3:0]  settle_cnt_r;
   logic        busy_r;
   logic        done_r;
   logic        pass_r;
   logic [11:0] err_count_r;
   logic [3:0]  fail_a_r;
   logic [3:0]  fail_b_r;
   logic [2:0]  fail_op_r;
   logic [3:0]  fail_out_r;
   logic        mismatch_s;
   logic [11:0] err_next_s;
   logic        last_vec_s;

   // Golden result of the ALU for one vector, 4-bit modulo 16
   function automatic logic [3:0] expected_result(input logic [2:0] op,
                                                  input logic [3:0] a,
                                                  input logic [3:0] b);
      logic [3:0] r;
      case (op)
         3'd0:    r = a + b;
         3'd1:    r = a - b;
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = a ^ b;
         3'd5:    r = ~a;
         3'd6:    r = {a[2:0], 1'b0};
         3'd7:    r = {1'b0, a[3:1]};
         default: r = 4'd0;
      endcase
      return r;
   endfunction

   // Operands come straight from the vector index register, so they hold in SETTLE/CHECK/DONE
   assign alu_op    = idx_r[10:8];
   assign alu_a     = idx_r[7:4];
   assign alu_b     = idx_r[3:0];
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign err_count = err_count_r;
   assign fail_a    = fail_a_r;
   assign fail_b    = fail_b_r;
   assign fail_op   = fail_op_r;
   assign fail_out  = fail_out_r;

   // Compare the returned result and form the saturating next error count
   always_comb begin
      mismatch_s = 1'b0;
      err_next_s = err_count_r;
      if (state_r == ST_CHECK) begin
         mismatch_s = (alu_out != expected_result(idx_r[10:8], idx_r[7:4], idx_r[3:0]));
      end else begin
         mismatch_s = 1'b0;
      end
      if (mismatch_s && (err_count_r != ERR_MAX)) begin
         err_next_s = err_count_r + 12'd1;
      end else begin
         err_next_s = err_count_r;
      end
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
      last_vec_s = (idx_r == IDX_LAST) || mismatch_s;
`else
      last_vec_s = (idx_r == IDX_LAST);
`endif
   end

   // Sweep sequencer: state, vector index, settle timer and all registered status
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         idx_r        <= 11'd0;
         settle_cnt_r <= 4'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         err_count_r  <= 12'd0;
         fail_a_r     <= 4'd0;
         fail_b_r     <= 4'd0;
         fail_op_r    <= 3'd0;
         fail_out_r   <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r     <= ST_APPLY;
                  idx_r       <= 11'd0;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
                  pass_r      <= 1'b0;
                  err_count_r <= 12'd0;
                  fail_a_r    <= 4'd0;
                  fail_b_r    <= 4'd0;
                  fail_op_r   <= 3'd0;
                  fail_out_r  <= 4'd0;
               end
            end
            ST_APPLY: begin
               state_r      <= ST_SETTLE;
               settle_cnt_r <= SETTLE_LAST;
            end
            ST_SETTLE: begin
               if (settle_cnt_r == 4'd0) begin
                  state_r <= ST_CHECK;
               end else begin
                  settle_cnt_r <= settle_cnt_r - 4'd1;
               end
            end
            ST_CHECK: begin
               err_count_r <= err_next_s;
               // Only the first mismatch of a sweep is captured
               if (mismatch_s && (err_count_r == 12'd0)) begin
                  fail_op_r  <= idx_r[10:8];
                  fail_a_r   <= idx_r[7:4];
                  fail_b_r   <= idx_r[3:0];
                  fail_out_r <= alu_out;
               end
               if (last_vec_s) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (err_next_s == 12'd0);
               end else begin
                  state_r <= ST_APPLY;
                  idx_r   <= idx_r + 11'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               pass_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_selftest.md
ALU_SELFTEST -- requirements
Module: alu_selftest

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning ALU settle cycles per vector, legal 1..15.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a sweep.
REQ-005 SHALL have port alu_a  output  4  operand a driven to the ALU under test.
REQ-006 SHALL have port alu_b  output  4  operand b driven to the ALU under test.
REQ-007 SHALL have port alu_op  output  3  opcode driven to the ALU under test.
REQ-008 SHALL have port alu_out  input  4  result returned from the ALU under test.
REQ-009 SHALL have port busy  output  1  high while a sweep is running.
REQ-010 SHALL have port done  output  1  high level from sweep completion until the next start.
REQ-011 SHALL have port pass  output  1  valid when done; high iff err_count == 0.
REQ-012 SHALL have port err_count  output  12  number of mismatching vectors.
REQ-013 SHALL have ports fail_a/fail_b (4), fail_op (3), fail_out (4)  output  capture of the first mismatching vector and its observed result.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, SETTLE, CHECK, DONE; all outputs registered.
REQ-015 SHALL use an 11-bit vector index i: alu_op = i[10:8], alu_a = i[7:4], alu_b = i[3:0]; 2048 vectors in ascending order.
REQ-016 IDLE or DONE with start=1 SHALL clear i, err_count, fail_* and done, then enter APPLY.
REQ-017 APPLY SHALL drive alu_a/alu_b/alu_op from i for exactly 1 cycle, then enter SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE cycles with the operands held stable, then enter CHECK.
REQ-019 CHECK SHALL compare alu_out with the expected value for 1 cycle; on mismatch it SHALL increment err_count and, if it is the first mismatch, load fail_*.
REQ-020 After CHECK: if i == 2047, enter DONE; otherwise increment i and enter APPLY. Each vector SHALL take SETTLE+2 cycles.
REQ-021 Expected results, 4-bit modulo 16: op0 a+b; op1 a-b; op2 a&b; op3 a|b; op4 a^b; op5 ~a; op6 a<<1; op7 a>>1 (logical).
REQ-022 busy SHALL be high in APPLY/SETTLE/CHECK; done SHALL be high only in DONE; pass SHALL equal done && err_count==0.
REQ-023 start SHALL be ignored while busy is high.
REQ-024 err_count SHALL never wrap; its maximum value is 2048.
REQ-025 alu_a/alu_b/alu_op SHALL hold their last driven value in DONE.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, i=0, alu_a/alu_b/alu_op=0, busy=done=pass=0, err_count=0, fail_*=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep immediately; no partial results are retained.
REQ-028 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 With macro ALU_SELFTEST_STOP_ON_FAIL_EN defined, a mismatch in CHECK SHALL go directly to DONE with err_count=1 and fail_* loaded.
REQ-030 Without ALU_SELFTEST_STOP_ON_FAIL_EN, the sweep SHALL always run all 2048 vectors.

Verification
REQ-031 Correct ALU model, SETTLE=1: pulse start -> busy high for 6144 cycles, then done=1, pass=1, err_count=0.
REQ-032 ALU with alu_out[0] stuck at 0, macro undefined -> done with err_count=896, pass=0, fail_op=0, fail_a=0, fail_b=1, fail_out=0.
REQ-033 Same fault, ALU_SELFTEST_STOP_ON_FAIL_EN defined -> done=1 on the 6th cycle after start, err_count=1, fail_b=1.
REQ-034 rst_n low for 1 cycle at vector 100 -> all outputs 0 and IDLE next cycle; a new start re-sweeps from i=0.
REQ-035 start pulsed while busy and again in DONE -> the first pulse is ignored; the second clears done and restarts the sweep.
REQ-036 SETTLE=3, correct ALU -> sweep takes 10240 cycles and operands stay stable throughout each SETTLE window.
